lpm_pipe: RTL and testbench
===========================

Name: lpm_pipe

Overview:
- Parametrised longest-prefix-match walker.
- Accepts lookup requests (meth, v) and walks a trie held in an external in-order memory.
- Recirculates each request through memory until a terminal node or an iteration limit is reached, then emits the result on an indication channel.
- Successor to the fixed single-slot LPM: configurable width, in-flight depth, queue depths and iteration limit; per-request iteration count; terminal-bit early exit.

Parameters:
- DATA_W, 32, width of meth, v and memory data.
- ADDR_W, 16, memory address width (ADDR_W <= DATA_W - 1).
- DEPTH, 4, max requests in flight in memory (power of 2, >= 2).
- IN_DEPTH, 2, input queue entries (power of 2).
- OUT_DEPTH, 2, output queue entries (power of 2).
- MAX_ITER, 5, max memory accesses per request (1..255).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- say__ENA  in  1  request valid; only asserted when say__RDY=1.
- say_meth  in  DATA_W  request tag.
- say_v  in  DATA_W  lookup key.
- say__RDY  out  1  input queue not full.
- indication$heard__ENA  out  1  result fire.
- indication$heard_meth  out  DATA_W  tag of completed request.
- indication$heard_v  out  DATA_W  final memory word.
- indication$heard_iter  out  8  memory accesses used (1..MAX_ITER).
- indication$heard__RDY  in  1  consumer ready.
- mem$req__ENA  out  1  memory read request.
- mem$req_addr  out  ADDR_W  read address.
- mem$req__RDY  in  1  memory accepts request.
- mem$resValue  in  DATA_W  read data, returned in request order.
- mem$resValue__RDY  in  1  response valid.
- mem$resAccept__ENA  out  1  response consumed.

Behaviour:
- Reset (nRST low, async):
  - All queues empty; in-flight count 0.
  - Outputs: say__RDY=0 while nRST low, then 1 from the first edge after deassertion. indication$heard__ENA=0, mem$req__ENA=0, mem$resAccept__ENA=0. Data outputs 0.
  - Reset mid-operation discards all in-flight and queued requests; no response is consumed after reset until a new request is issued.
- say: fires when say__ENA & say__RDY. Pushes {meth, v} into input queue. say__RDY = !inQ_full.
- In-flight tracker: circular FIFO of DEPTH entries {meth, iter}, same order as outstanding memory requests; fl_count = occupancy.
- Response handling, when mem$resValue__RDY. Let term = mem$resValue[DATA_W-1] | (head.iter == MAX_ITER).
  - exit (term=1): fires when outQ not full. Pops tracker head; pushes {head.meth, resValue, head.iter} to outQ; asserts mem$resAccept__ENA.
  - recirc (term=0): fires when mem$req__RDY. Issues mem$req_addr = resValue[ADDR_W-1:0]; pops head and pushes {meth, iter+1} in the same cycle (fl_count unchanged); asserts mem$resAccept__ENA.
  - Otherwise the response is held; mem$resAccept__ENA=0.
- enter: fires when inQ non-empty & mem$req__RDY & fl_count < DEPTH & recirc not firing this cycle.
  - Pops inQ; mem$req_addr = v[ADDR_W-1:0]; pushes {meth, iter=1}.
  - Recirc has strict priority over enter: one memory request per cycle.
- Simultaneous exit and enter: fl_count unchanged; enter is permitted even when fl_count == DEPTH, since a slot frees this cycle.
- mem$req__ENA = enter | recirc; mem$resAccept__ENA = exit | recirc.
- respond: indication$heard__ENA = outQ non-empty & indication$heard__RDY. Data driven from outQ head. Pop on fire.
- Latency:
  - say to first mem request: 1 cycle minimum (registered inQ).
  - exit to indication: 1 cycle minimum.
- Queue pointers wrap modulo depth. Full/empty use an extra pointer bit. No overflow or underflow is possible by construction.
- iter is 8 bits and never exceeds MAX_ITER.

Optional Feature:
- LPM_STATS_EN defined:
  - Adds outputs stat_done (32), stat_recirc (32), stat_stall (32), reset to 0.
  - Increments: on exit; on recirc; on cycles with inQ non-empty and enter blocked.
  - All three saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist.

Test Plan:
- Single request meth=7, v=0x10; memory returns 0x80000020 (terminal) after 3 cycles -> one mem request addr 0x0010; heard meth=7, v=0x80000020, iter=1.
- MAX_ITER=5, memory always non-terminal, returns addr+1 -> requests at 0x10..0x14 (5 total); heard iter=5, v=last response; no 6th request.
- 6 back-to-back requests, DEPTH=4, memory latency 10 -> at most 4 outstanding; say__RDY drops once inQ is full; all 6 results in issue order.
- indication$heard__RDY held 0 for 20 cycles with terminal responses -> outQ fills; mem$resAccept__ENA stays 0; no result lost; drain order preserved.
- Recirc and enter contend in the same cycle -> only the recirc address is issued; enter issues next cycle.
- Assert nRST low mid-walk with 3 in flight -> outputs 0 immediately; after release, a new request completes with iter=1.

Source files
------------

// File: rtl/lpm_pipe.sv
// lpm_pipe: longest-prefix-match trie walker.
// Requests queue in inQ and enter the memory pipeline. Each memory response
// either exits the request to outQ (terminal bit or iteration limit reached)
// or is recirculated as the address of the next memory read.
// Optional statistics counters are built when LPM_STATS_EN is defined.
module lpm_pipe #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned IN_DEPTH  = 2,
   parameter int unsigned OUT_DEPTH = 2,
   parameter int unsigned MAX_ITER  = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              say__ENA,
   input  logic [DATA_W-1:0] say_meth,
   input  logic [DATA_W-1:0] say_v,
   output logic              say__RDY,
   output logic              indication_heard__ENA,
   output logic [DATA_W-1:0] indication_heard_meth,
   output logic [DATA_W-1:0] indication_heard_v,
   output logic [7:0]        indication_heard_iter,
   input  logic              indication_heard__RDY,
   output logic              mem_req__ENA,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req__RDY,
   input  logic [DATA_W-1:0] mem_resValue,
   input  logic              mem_resValue__RDY,
   output logic              mem_resAccept__ENA
`ifdef LPM_STATS_EN
   ,
   output logic [31:0]       stat_done,
   output logic [31:0]       stat_recirc,
   output logic [31:0]       stat_stall
`endif
);

   localparam int unsigned IA  = $clog2(IN_DEPTH);
   localparam int unsigned OA  = $clog2(OUT_DEPTH);
   localparam int unsigned FA  = $clog2(DEPTH);
   localparam int unsigned IPW = IA + 1;
   localparam int unsigned OPW = OA + 1;
   localparam int unsigned FPW = FA + 1;
   localparam int unsigned IXW = (IA > 0) ? IA : 1;
   localparam int unsigned OXW = (OA > 0) ? OA : 1;
   localparam int unsigned IEW = DATA_W + ADDR_W;
   localparam int unsigned OEW = 2 * DATA_W + 8;

   logic                rdy_q;

   logic [IEW-1:0]      inq_mem_q [IN_DEPTH];
   logic [IPW-1:0]      inq_wp_q, inq_rp_q, inq_wp_d, inq_rp_d;
   logic [IXW-1:0]      inq_wr_idx, inq_rd_idx;
   logic                inq_empty, inq_full;
   logic [DATA_W-1:0]   inq_meth;
   logic [ADDR_W-1:0]   inq_addr;

   logic [DATA_W-1:0]   fl_meth_q [DEPTH];
   logic [7:0]          fl_iter_q [DEPTH];
   logic [FPW-1:0]      fl_wp_q, fl_rp_q, fl_wp_d, fl_rp_d;
   logic                fl_empty, fl_full;
   logic [DATA_W-1:0]   head_meth;
   logic [7:0]          head_iter;

   logic [OEW-1:0]      outq_mem_q [OUT_DEPTH];
   logic [OPW-1:0]      outq_wp_q, outq_rp_q, outq_wp_d, outq_rp_d;
   logic [OXW-1:0]      outq_wr_idx, outq_rd_idx;
   logic                outq_empty, outq_full;

   logic                say_fire, heard_fire, res_pend, res_term;
   logic                exit_c, recirc_c, enter_c;
   logic                unused_key_hi;

   // Upper key bits do not take part in trie addressing.
   assign unused_key_hi = ^say_v[DATA_W-1:ADDR_W];

   assign inq_wr_idx  = IXW'(inq_wp_q % IPW'(IN_DEPTH));
   assign inq_rd_idx  = IXW'(inq_rp_q % IPW'(IN_DEPTH));
   assign inq_empty   = (inq_wp_q == inq_rp_q);
   assign inq_full    = (IPW'(inq_wp_q - inq_rp_q) == IPW'(IN_DEPTH));
   assign {inq_meth, inq_addr} = inq_mem_q[inq_rd_idx];

   assign fl_empty    = (fl_wp_q == fl_rp_q);
   assign fl_full     = (FPW'(fl_wp_q - fl_rp_q) == FPW'(DEPTH));
   assign head_meth   = fl_meth_q[fl_rp_q[FA-1:0]];
   assign head_iter   = fl_iter_q[fl_rp_q[FA-1:0]];

   assign outq_wr_idx = OXW'(outq_wp_q % OPW'(OUT_DEPTH));
   assign outq_rd_idx = OXW'(outq_rp_q % OPW'(OUT_DEPTH));
   assign outq_empty  = (outq_wp_q == outq_rp_q);
   assign outq_full   = (OPW'(outq_wp_q - outq_rp_q) == OPW'(OUT_DEPTH));

   assign say__RDY              = rdy_q & ~inq_full;
   assign indication_heard__ENA = ~outq_empty & indication_heard__RDY;
   assign {indication_heard_meth, indication_heard_v, indication_heard_iter} = outq_mem_q[outq_rd_idx];
   assign mem_req__ENA          = enter_c | recirc_c;
   assign mem_resAccept__ENA    = exit_c | recirc_c;

   // Arbitration: recirculation beats new entry; one memory request per cycle.
   always_comb begin
      say_fire     = say__ENA & say__RDY;
      heard_fire   = ~outq_empty & indication_heard__RDY;
      res_pend     = mem_resValue__RDY & ~fl_empty;
      res_term     = mem_resValue[DATA_W-1] | (head_iter == 8'(MAX_ITER));
      exit_c       = res_pend & res_term & ~outq_full;
      recirc_c     = res_pend & ~res_term & mem_req__RDY;
      enter_c      = ~inq_empty & mem_req__RDY & (~fl_full | exit_c) & ~recirc_c;
      mem_req_addr = '0;
      if (recirc_c) begin
         mem_req_addr = mem_resValue[ADDR_W-1:0];
      end else if (enter_c) begin
         mem_req_addr = inq_addr;
      end
      inq_wp_d  = say_fire   ? inq_wp_q + IPW'(1)  : inq_wp_q;
      inq_rp_d  = enter_c    ? inq_rp_q + IPW'(1)  : inq_rp_q;
      fl_wp_d   = (enter_c | recirc_c) ? fl_wp_q + FPW'(1) : fl_wp_q;
      fl_rp_d   = (exit_c | recirc_c)  ? fl_rp_q + FPW'(1) : fl_rp_q;
      outq_wp_d = exit_c     ? outq_wp_q + OPW'(1) : outq_wp_q;
      outq_rp_d = heard_fire ? outq_rp_q + OPW'(1) : outq_rp_q;
   end

   // Input ready comes up on the first clock edge after reset release.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) rdy_q <= 1'b0;
      else       rdy_q <= 1'b1;
   end

   // Input queue of {tag, trie address}.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         inq_wp_q <= '0;
         inq_rp_q <= '0;
         for (int i = 0; i < int'(IN_DEPTH); i++) inq_mem_q[i] <= '0;
      end else begin
         if (say_fire) inq_mem_q[inq_wr_idx] <= {say_meth, say_v[ADDR_W-1:0]};
         inq_wp_q <= inq_wp_d;
         inq_rp_q <= inq_rp_d;
      end
   end

   // In-flight tracker, kept in the same order as outstanding memory reads.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fl_wp_q <= '0;
         fl_rp_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fl_meth_q[i] <= '0;
            fl_iter_q[i] <= '0;
         end
      end else begin
         if (recirc_c) begin
            fl_meth_q[fl_wp_q[FA-1:0]] <= head_meth;
            fl_iter_q[fl_wp_q[FA-1:0]] <= head_iter + 8'd1;
         end else if (enter_c) begin
            fl_meth_q[fl_wp_q[FA-1:0]] <= inq_meth;
            fl_iter_q[fl_wp_q[FA-1:0]] <= 8'd1;
         end
         fl_wp_q <= fl_wp_d;
         fl_rp_q <= fl_rp_d;
      end
   end

   // Output queue of completed {tag, final word, iteration count}.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         outq_wp_q <= '0;
         outq_rp_q <= '0;
         for (int i = 0; i < int'(OUT_DEPTH); i++) outq_mem_q[i] <= '0;
      end else begin
         if (exit_c) outq_mem_q[outq_wr_idx] <= {head_meth, mem_resValue, head_iter};
         outq_wp_q <= outq_wp_d;
         outq_rp_q <= outq_rp_d;
      end
   end

`ifdef LPM_STATS_EN
   logic [31:0] stat_done_q, stat_recirc_q, stat_stall_q;
   logic [31:0] stat_done_d, stat_recirc_d, stat_stall_d;

   // Saturating event counters.
   always_comb begin
      stat_done_d   = stat_done_q;
      stat_recirc_d = stat_recirc_q;
      stat_stall_d  = stat_stall_q;
      if (exit_c && stat_done_q != 32'hFFFF_FFFF)               stat_done_d   = stat_done_q + 32'd1;
      if (recirc_c && stat_recirc_q != 32'hFFFF_FFFF)           stat_recirc_d = stat_recirc_q + 32'd1;
      if (!inq_empty && !enter_c && stat_stall_q != 32'hFFFF_FFFF) stat_stall_d = stat_stall_q + 32'd1;
   end

   // Statistics registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_done_q   <= '0;
         stat_recirc_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         stat_done_q   <= stat_done_d;
         stat_recirc_q <= stat_recirc_d;
         stat_stall_q  <= stat_stall_d;
      end
   end

   assign stat_done   = stat_done_q;
   assign stat_recirc = stat_recirc_q;
   assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_lpm_pipe.sv
// Bench for lpm_pipe: in-order memory responder, trie-walk reference model
// and tag-keyed scoreboard.
module tb_lpm_pipe;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned IN_DEPTH  = 2;
   localparam int unsigned OUT_DEPTH = 2;
   localparam int unsigned MAX_ITER  = 5;
   localparam int M_TERM = 0;
   localparam int M_INC  = 1;
   localparam int M_RAND = 2;

   logic        clk = 1'b0;
   logic        nrst;
   logic        say_ena, say_rdy;
   logic [31:0] say_meth, say_v;
   logic        heard_ena, heard_rdy;
   logic [31:0] heard_meth, heard_v;
   logic [7:0]  heard_iter;
   logic        req_ena, req_rdy;
   logic [15:0] req_addr;
   logic [31:0] res_val;
   logic        res_rdy, res_acc;

   always #5 clk = ~clk;

   lpm_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IN_DEPTH(IN_DEPTH),
              .OUT_DEPTH(OUT_DEPTH), .MAX_ITER(MAX_ITER)) dut (
      .CLK(clk), .nRST(nrst),
      .say__ENA(say_ena), .say_meth(say_meth), .say_v(say_v), .say__RDY(say_rdy),
      .indication_heard__ENA(heard_ena), .indication_heard_meth(heard_meth),
      .indication_heard_v(heard_v), .indication_heard_iter(heard_iter),
      .indication_heard__RDY(heard_rdy),
      .mem_req__ENA(req_ena), .mem_req_addr(req_addr), .mem_req__RDY(req_rdy),
      .mem_resValue(res_val), .mem_resValue__RDY(res_rdy), .mem_resAccept__ENA(res_acc));

   typedef struct { logic [15:0] addr; int due; int iter; } mreq_t;

   mreq_t       mq[$];
   logic [15:0] vq[$];
   logic [15:0] alog[$];
   int          ord_q[$];
   logic [31:0] exp_v[int];
   int          exp_it[int];

   int n_checks = 0, n_errors = 0;
   int cyc = 0, n_req = 0, n_acc = 0, n_heard = 0, n_contend = 0, max_fl = 0;
   int mode = M_TERM, lat_lo = 3, lat_hi = 3, req_pct = 100, rsp_pct = 100, heard_pct = 100;
   bit hold_heard = 0, chk_order = 0, acc_last = 0;
   logic [31:0] last_meth = 0, last_v = 0;
   int          last_iter = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Trie contents: terminal (addr*2 with bit31), incrementing chain, or hashed.
   function automatic logic [31:0] memfn(input int md, input logic [15:0] a);
      logic [31:0] h;
      if (md == M_TERM) return 32'h8000_0000 | (32'(a) << 1);
      if (md == M_INC)  return {16'h0, a + 16'd1};
      h = {a, ~a} * 32'h9E37_79B1;
      h = h ^ (h >> 13);
      return {(h[2:0] < 3'd3), h[30:0]};
   endfunction

   // Reference walk: follow words until terminal bit or the access limit.
   function automatic void walk(input int md, input logic [15:0] a0,
                                output logic [31:0] w, output int it);
      logic [15:0] a = a0;
      bit done = 0;
      w = 0; it = 0;
      for (int i = 1; i <= int'(MAX_ITER); i++) begin
         if (!done) begin
            w = memfn(md, a);
            it = i;
            if (w[31]) done = 1;
            a = w[15:0];
         end
      end
   endfunction

   // Monitor: tracks outstanding reads with their expected iteration count.
   mreq_t       fr;
   logic        term_f;
   int          nit, key, wit;
   logic [31:0] ww;
   always @(posedge clk) begin
      cyc++;
      if (!nrst) begin
         mq.delete(); vq.delete(); ord_q.delete(); exp_v.delete(); exp_it.delete();
      end else begin
         term_f = 0;
         if (res_acc) begin
            n_acc++;
            check_eq("acc_valid", res_rdy, 1);
            check_eq("acc_outstanding", mq.size() > 0, 1);
            if (mq.size() > 0) begin
               fr = mq.pop_front();
               term_f = res_val[31] || (fr.iter == int'(MAX_ITER));
            end
         end
         if (req_ena) begin
            n_req++;
            alog.push_back(req_addr);
            check_eq("req_rdy", req_rdy, 1);
            if (res_acc && !term_f) begin
               check_eq("recirc_addr", req_addr, res_val[15:0]);
               nit = fr.iter + 1;
               if (vq.size() > 0) n_contend++;
            end else begin
               check_eq("enter_src", vq.size() > 0, 1);
               if (vq.size() > 0) check_eq("enter_addr", req_addr, vq.pop_front());
               nit = 1;
            end
            mq.push_back('{req_addr, cyc + int'($urandom_range(lat_hi, lat_lo)), nit});
            check_eq("inflight_max", mq.size() <= int'(DEPTH), 1);
            if (mq.size() > max_fl) max_fl = mq.size();
         end
         if (say_ena && say_rdy) begin
            vq.push_back(say_v[15:0]);
            walk(mode, say_v[15:0], ww, wit);
            exp_v[int'(say_meth)] = ww;
            exp_it[int'(say_meth)] = wit;
            if (chk_order) ord_q.push_back(int'(say_meth));
         end
         if (heard_ena) begin
            n_heard++;
            key = int'(heard_meth);
            last_meth = heard_meth; last_v = heard_v; last_iter = int'(heard_iter);
            check_eq("heard_known", exp_v.exists(key), 1);
            if (exp_v.exists(key)) begin
               check_eq("heard_v", heard_v, exp_v[key]);
               check_eq("heard_iter", heard_iter, exp_it[key]);
               exp_v.delete(key);
               exp_it.delete(key);
            end
            if (chk_order && ord_q.size() > 0) check_eq("heard_order", heard_meth, ord_q.pop_front());
         end
      end
      acc_last = nrst && res_acc;
   end

   // In-order memory responder and random ready generation.
   always @(negedge clk) begin
      if (!nrst) begin
         res_rdy = 0; res_val = 0; req_rdy = 0; heard_rdy = 0;
      end else begin
         if (res_rdy && acc_last) begin
            res_rdy = 0; res_val = 0;
         end
         if (!res_rdy && mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99, 0) < rsp_pct) begin
            res_rdy = 1;
            res_val = memfn(mode, mq[0].addr);
         end
         req_rdy   = ($urandom_range(99, 0) < req_pct);
         heard_rdy = hold_heard ? 1'b0 : ($urandom_range(99, 0) < heard_pct);
      end
   end

   task automatic send(input int m, input logic [31:0] v);
      int t = 0;
      while (!say_rdy && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) begin
         check_eq("send_timeout", say_rdy, 1);
         return;
      end
      say_ena = 1; say_meth = 32'(m); say_v = v;
      @(negedge clk);
      say_ena = 0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_v.num() != 0 || mq.size() != 0 || vq.size() != 0) && t < 3000) begin
         @(negedge clk); t++;
      end
      if (t >= 3000) check_eq("drain_timeout", exp_v.num(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int base, h0, a0, c0, t;
      nrst = 0; say_ena = 0; say_meth = 0; say_v = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_say_rdy", say_rdy, 0);
      check_eq("rst_heard_ena", heard_ena, 0);
      check_eq("rst_req_ena", req_ena, 0);
      check_eq("rst_acc", res_acc, 0);
      check_eq("rst_heard_data", {heard_meth, heard_v}, 0);
      check_eq("rst_heard_iter", heard_iter, 0);
      nrst = 1;
      #1 check_eq("rdy_before_edge", say_rdy, 0);
      @(posedge clk); #1 check_eq("rdy_after_edge", say_rdy, 1);
      @(negedge clk);

      // Single terminal lookup.
      base = n_req; h0 = n_heard;
      send(7, 32'h10);
      drain();
      check_eq("p1_nreq", n_req - base, 1);
      check_eq("p1_addr", alog[base], 16'h0010);
      check_eq("p1_nheard", n_heard - h0, 1);
      check_eq("p1_result", {last_meth, last_v}, {32'd7, 32'h8000_0020});
      check_eq("p1_iter", last_iter, 1);

      // Iteration limit on a never-terminating chain.
      mode = M_INC; base = n_req;
      send(8, 32'h10);
      drain();
      check_eq("p2_nreq", n_req - base, 5);
      for (int k = 0; k < 5; k++) check_eq("p2_addr", alog[base + k], 16'(16'h10 + k));
      check_eq("p2_v", last_v, 32'h15);
      check_eq("p2_iter", last_iter, 5);

      // Back-to-back requests with long latency.
      mode = M_TERM; lat_lo = 10; lat_hi = 10; chk_order = 1; h0 = n_heard;
      for (int i = 0; i < 6; i++) send(20 + i, $urandom());
      check_eq("p3_rdy_low", say_rdy, 0);
      drain();
      check_eq("p3_nheard", n_heard - h0, 6);
      check_eq("p3_max_inflight", max_fl, DEPTH);

      // Consumer stalled: output queue fills and responses are held.
      lat_lo = 2; lat_hi = 2; hold_heard = 1;
      @(negedge clk);
      a0 = n_acc; h0 = n_heard;
      for (int i = 0; i < 5; i++) send(40 + i, $urandom());
      repeat (20) @(negedge clk);
      check_eq("p4_acc_held", n_acc - a0, OUT_DEPTH);
      check_eq("p4_no_heard", n_heard - h0, 0);
      check_eq("p4_acc_low", res_acc, 0);
      check_eq("p4_res_waiting", res_rdy, 1);
      hold_heard = 0;
      drain();
      check_eq("p4_nheard", n_heard - h0, 5);
      chk_order = 0;

      // Recirculation contending with a waiting entry.
      mode = M_INC; lat_lo = 0; lat_hi = 0; c0 = n_contend;
      send(50, 32'h100);
      send(51, 32'h200);
      drain();
      check_eq("p5_contend", n_contend > c0, 1);

      // Randomised traffic and handshakes.
      mode = M_RAND; lat_lo = 0; lat_hi = 6; req_pct = 70; rsp_pct = 70; heard_pct = 60;
      h0 = n_heard;
      for (int i = 0; i < 40; i++) begin
         send(100 + i, $urandom());
         repeat ($urandom_range(2, 0)) @(negedge clk);
      end
      drain();
      check_eq("p6_nheard", n_heard - h0, 40);

      // Reset in the middle of a walk.
      mode = M_INC; lat_lo = 8; lat_hi = 8; req_pct = 100; rsp_pct = 100; heard_pct = 100;
      for (int i = 0; i < 3; i++) send(200 + i, $urandom());
      t = 0;
      while (mq.size() != 3 && t < 50) begin @(negedge clk); t++; end
      check_eq("p7_inflight", mq.size(), 3);
      nrst = 0;
      #1;
      check_eq("p7_say_rdy", say_rdy, 0);
      check_eq("p7_req_ena", req_ena, 0);
      check_eq("p7_acc", res_acc, 0);
      check_eq("p7_heard_ena", heard_ena, 0);
      check_eq("p7_heard_v", heard_v, 0);
      repeat (3) @(negedge clk);
      mode = M_TERM; lat_lo = 2; lat_hi = 2;
      nrst = 1;
      @(negedge clk);
      a0 = n_acc; h0 = n_heard;
      repeat (4) @(negedge clk);
      check_eq("p7_no_stale_acc", n_acc - a0, 0);
      send(300, 32'h40);
      drain();
      check_eq("p7_nheard", n_heard - h0, 1);
      check_eq("p7_result", {last_meth, last_v}, {32'd300, 32'h8000_0080});
      check_eq("p7_iter", last_iter, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end
endmodule
